serial_add_sub: RTL and testbench

Bit-serial adder/subtractor that drives a single 1-bit full adder cell, one bit per clock, LSB first. It registers the cell's carry-out and feeds it back as the next carry-in. It collects the sum bits into a WIDTH-bit result. Used as the low-area multi-cycle arithmetic option for the ALU/execute path, with a start/busy/done handshake toward the control unit.

---
 rtl/serial_add_sub.sv | 106 ++++++++++
 tb/tb_serial_add_sub.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock, LSB first,
// with a registered carry loop and a start/busy/done handshake.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa_sh, opb_sh, sum_sh, sum_next;
  logic [CW-1:0]    cnt;
  logic             carry, a_msb, b_msb;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .x  (opa_sh[0]),
    .y  (opb_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum word as it stands once the current bit lands at the MSB.
  assign sum_next = {fa_s, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opa_sh   <= '0;
      opb_sh   <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (start) begin
            // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
            opa_sh <= a;
            opb_sh <= sub ? ~b : b;
            carry  <= sub;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          opa_sh <= opa_sh >> 1;
          opb_sh <= opb_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_co;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            result   <= sum_next;
            cout     <= fa_co;
            overflow <= (a_msb == b_msb) && (fa_s != a_msb);
            zero     <= ~|sum_next;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// Randomized and directed checks of serial_add_sub against a plain-arithmetic reference.

module tb_serial_add_sub;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned result/carry and true signed overflow from integer arithmetic.
  task automatic model(input logic [W-1:0] ia, ib, input logic is,
                       output logic [W-1:0] r, output logic c, v, z);
    longint sr;
    logic [W:0] wide;
    if (is) begin
      r  = ia - ib;
      c  = (ia >= ib);
      sr = longint'($signed(ia)) - longint'($signed(ib));
    end else begin
      wide = {1'b0, ia} + {1'b0, ib};
      r  = wide[W-1:0];
      c  = wide[W];
      sr = longint'($signed(ia)) + longint'($signed(ib));
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    z = (r == '0);
  endtask

  task automatic do_op(input logic [W-1:0] ia, ib, input logic is, input bit poke);
    logic [W-1:0] er, cr;
    logic ec, ev, ez, cc, cv, cz;
    int lat, nbusy, ndone;
    lat = -1; nbusy = 0; ndone = 0;
    cr = '0; cc = 0; cv = 0; cz = 0;
    model(ia, ib, is, er, ec, ev, ez);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sub = is;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sub = $urandom_range(1);
    for (int k = 1; k <= W + 4; k++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = k - 1; cr = result; cc = cout; cv = overflow; cz = zero;
        end
      end
      if (poke && (k == 5 || k == 20)) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end else start = 1'b0;
      @(negedge clk);
    end
    chk("latency", lat, W);
    chk("busy_cycles", nbusy, W);
    chk("done_pulses", ndone, 1);
    chk("result", cr, er);
    chk("cout", cc, ec);
    chk("overflow", cv, ev);
    chk("zero", cz, ez);
    chk("result_held", result, er);
  endtask

  initial begin
    int gap, nd;
    logic [W-1:0] t;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, overflow, zero}, 0);

    do_op(32'd5, 32'd3, 1'b0, 0);
    do_op(32'd3, 32'd5, 1'b1, 0);
    do_op(32'd5, 32'd5, 1'b1, 0);
    do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'd0, 32'h8000_0000, 1'b1, 0);
    do_op(32'h8000_0000, 32'd1, 1'b1, 0);
    do_op(32'd100, 32'd23, 1'b0, 1);

    // Back-to-back with start held high: (1,2) then (10,20).
    @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd2; sub = 1'b0;
    @(negedge clk);
    a = 32'd10; b = 32'd20;
    gap = -1; nd = 0;
    for (int k = 1; k <= 2 * W + 6; k++) begin
      if (done) begin
        nd++;
        if (nd == 1) begin
          chk("b2b_first", result, 3);
          gap = 0;
          @(negedge clk);
          start = 1'b0;
          k++;
          gap++;
          continue;
        end else begin
          chk("b2b_gap", gap, W + 1);
          chk("b2b_second", result, 30);
        end
      end
      if (gap >= 0) gap++;
      if (nd == 1 && gap == 15) chk("b2b_hold", result, 3);
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_pulses", nd, 2);

    // Reset in the middle of an operation abandons it.
    @(negedge clk);
    start = 1'b1; a = 32'd40; b = 32'd2; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_result", result, 0);
    nd = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("mid_rst_no_done", nd, 0);
    do_op(32'd7, 32'd9, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      t = $urandom;
      case (i % 4)
        0: do_op(t, $urandom, $urandom_range(1), 0);
        1: do_op(t, t, 1'b1, 0);
        2: do_op({1'b0, t[W-2:0]}, {1'b0, t[W-1:1]}, 1'b0, 0);
        default: do_op(t, ~t + 32'd1, $urandom_range(1), 0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
